// File: rtl/matrix_operand_loader_if.sv
// Stream-in / operands-out bundle for matrix_operand_loader.
// The source and consumer sit on the master side; the loader is the slave.
interface matrix_operand_loader_if #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int M_COLS     = 4,
  parameter int DATA_WIDTH = 32
);
  // Handshake: an element moves on a rising clk edge where in_valid && in_ready.
  // in_ready depends only on loader state, never on in_valid. The operands are
  // held while mats_valid is high, and the consumer releases them by raising
  // mats_ready for one edge.
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_last;
  logic [DATA_WIDTH-1:0] memA [N_ROWS][N_COLS];
  logic [DATA_WIDTH-1:0] memB [N_COLS][M_COLS];
  logic                  mats_valid;
  logic                  mats_ready;
  logic                  frame_err;
  logic [1:0]            state_dbg;

  modport master (
    output in_data, in_valid, in_last, mats_ready,
    input  in_ready, memA, memB, mats_valid, frame_err, state_dbg
  );

  modport slave (
    input  in_data, in_valid, in_last, mats_ready,
    output in_ready, memA, memB, mats_valid, frame_err, state_dbg
  );
endinterface

// File: rtl/matrix_operand_loader.sv
// Collects matrix A, then matrix B, from a word-wide stream into registered arrays,
// and holds them for the multiplier until the consumer acknowledges them.
module matrix_operand_loader #(
  parameter int N_ROWS     = 4,
  parameter int N_COLS     = 4,
  parameter int M_COLS     = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  matrix_operand_loader_if.slave bus
);

  localparam int MAX_RC  = (N_ROWS > N_COLS) ? N_ROWS : N_COLS;
  localparam int MAX_DIM = (MAX_RC > M_COLS) ? MAX_RC : M_COLS;
  localparam int IDX_W   = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      row;
  logic [IDX_W-1:0]      col;
  logic [DATA_WIDTH-1:0] mem_a [N_ROWS][N_COLS];
  logic [DATA_WIDTH-1:0] mem_b [N_COLS][M_COLS];
  logic                  mats_valid_q;
  logic                  frame_err_q;

  logic xfer;
  logic col_end_a;
  logic col_end_b;
  logic last_a;
  logic last_b;

  // Held low during reset so nothing is accepted while arrays are being cleared.
  assign bus.in_ready = !rst && (state != FULL);
  assign xfer         = bus.in_valid && bus.in_ready;

  assign col_end_a = (col == IDX_W'(N_COLS - 1));
  assign col_end_b = (col == IDX_W'(M_COLS - 1));
  assign last_a    = col_end_a && (row == IDX_W'(N_ROWS - 1));
  assign last_b    = col_end_b && (row == IDX_W'(N_COLS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= LOAD_A;
      row          <= '0;
      col          <= '0;
      mem_a        <= '{default: '0};
      mem_b        <= '{default: '0};
      mats_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state)
        LOAD_A: begin
          if (xfer) begin
            mem_a[row][col] <= bus.in_data;
            if (bus.in_last) begin
              // Premature end of frame: keep the element, restart the frame.
              frame_err_q <= 1'b1;
              row         <= '0;
              col         <= '0;
            end else if (last_a) begin
              row   <= '0;
              col   <= '0;
              state <= LOAD_B;
            end else if (col_end_a) begin
              col <= '0;
              row <= row + IDX_W'(1);
            end else begin
              col <= col + IDX_W'(1);
            end
          end
        end

        LOAD_B: begin
          if (xfer) begin
            mem_b[row][col] <= bus.in_data;
            if (last_b) begin
              // A missing in_last is reported, but the frame is still delivered.
              frame_err_q  <= !bus.in_last;
              row          <= '0;
              col          <= '0;
              mats_valid_q <= 1'b1;
              state        <= FULL;
            end else if (bus.in_last) begin
              frame_err_q <= 1'b1;
              row         <= '0;
              col         <= '0;
              state       <= LOAD_A;
            end else if (col_end_b) begin
              col <= '0;
              row <= row + IDX_W'(1);
            end else begin
              col <= col + IDX_W'(1);
            end
          end
        end

        FULL: begin
          if (bus.mats_ready) begin
            mats_valid_q <= 1'b0;
            row          <= '0;
            col          <= '0;
            state        <= LOAD_A;
          end
        end

        default: begin
          state        <= LOAD_A;
          row          <= '0;
          col          <= '0;
          mats_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.memA       = mem_a;
  assign bus.memB       = mem_b;
  assign bus.mats_valid = mats_valid_q;
  assign bus.frame_err  = frame_err_q;
  assign bus.state_dbg  = state;

endmodule

// File: doc/matrix_operand_loader.md
Name: matrix_operand_loader

Overview:
- Upstream feeder for the combinational matrix multiplier.
- Accepts a single-word valid/ready stream carrying matrix A, then matrix B, both row-major.
- Assembles the words into registered memA/memB arrays and raises mats_valid once both matrices are complete.
- Holds both arrays stable until the consumer acknowledges them, then accepts the next frame.

Parameters:
N_ROWS, 4, rows of A
N_COLS, 4, columns of A and rows of B
M_COLS, 4, columns of B
DATA_WIDTH, 32, element width in bits

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_data  input  DATA_WIDTH  stream element
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader can accept an element this cycle
in_last  input  1  marks the final element of a frame (last B element)
memA  output  [DATA_WIDTH-1:0] [N_ROWS][N_COLS]  registered matrix A
memB  output  [DATA_WIDTH-1:0] [N_COLS][M_COLS]  registered matrix B
mats_valid  output  1  memA/memB complete and stable
mats_ready  input  1  consumer has taken the current operands
frame_err  output  1  one-cycle pulse on a framing error

Behaviour:
- Clock and reset: one clock (clk); rst is asynchronous and active-high.
- Reset values: state LOAD_A; row/col counters 0; memA and memB all zero; mats_valid 0; frame_err 0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Transfer rule: a transfer happens when in_valid && in_ready at a rising clk edge. No other cycle changes the arrays.
- in_ready: 1 in LOAD_A and LOAD_B, 0 in FULL. It is decoded from state, with no combinational path from in_valid.
- States:
  - LOAD_A: each transfer writes memA[row][col]. col increments and wraps at N_COLS-1, incrementing row. On the transfer with row=N_ROWS-1 and col=N_COLS-1: counters clear and the state moves to LOAD_B.
  - LOAD_B: each transfer writes memB[row][col], with col wrapping at M_COLS-1. On the transfer with row=N_COLS-1 and col=M_COLS-1: state moves to FULL and mats_valid becomes 1 in the next cycle. There is no extra latency: mats_valid is registered in the same edge as the final write.
  - FULL: arrays are frozen. When mats_ready=1 at an edge, the state returns to LOAD_A, counters clear and mats_valid falls to 0. memA/memB keep their old contents until overwritten element by element.
- mats_ready while not FULL: ignored.
- Handoff edge: FULL to LOAD_A takes one edge, and no element is accepted on that edge because in_ready=0. The first element of the next frame can be accepted on the following edge. Throughput is therefore one frame per N_ROWS*N_COLS + N_COLS*M_COLS + 1 cycles at best.
- Framing checks (in_last is sampled only on transfers):
  - in_last=1 on any element other than the final B element: the element is written normally. frame_err pulses for 1 cycle, counters clear and the state returns to LOAD_A. Partial contents are not flagged, and mats_valid stays 0.
  - in_last=0 on the final B element: frame_err pulses for 1 cycle and the frame still completes to FULL.
- Reset mid-operation: rst asserted in any state immediately forces all reset values, including zeroed arrays. Any partial frame is discarded.
- Index arithmetic: row/col counters are sized with $clog2 of the maximum dimension, minimum 1 bit. Wrap compares are against parameter minus 1; there is no modulo hardware.
- Supported shapes: all parameters must be at least 1. 1x1x1 is legal: a frame is 2 elements, A then B.

Test Plan:
- Defaults, stream 1..32 with in_valid held high and in_last on the 32nd element:
  - memA[0][0]=1, memA[3][3]=16, memB[0][0]=17, memB[3][3]=32.
  - mats_valid=1 the cycle after the 32nd transfer; in_ready=0 while FULL.
- Stall then release: hold FULL for 5 cycles with mats_ready=0, then pulse mats_ready.
  - Arrays unchanged during the stall; mats_valid drops.
  - in_ready=1 the next cycle; new element 100 lands in memA[0][0] on the following transfer.
- Source gaps: drive in_valid as a 1-0-0-1 pattern while streaming.
  - No writes on idle cycles; final contents are identical to the gapless run.
- Early in_last on element 10 (memA[2][1]):
  - frame_err is high for exactly 1 cycle and the state is LOAD_A.
  - The next element, 55, is written to memA[0][0] and mats_valid stays 0.
- Missing in_last on element 32:
  - frame_err pulses once; mats_valid=1 and memB[3][3]=32.
- Reset mid-frame: rst asserted asynchronously after element 20.
  - All memA/memB read 0 and mats_valid=0 immediately.
  - After release, a full 1..32 frame loads correctly.
